// File: rtl/rv_multicycle_control_fsm.sv
// rv_multicycle_control_fsm: RV32I multi-cycle main control sequencer with memory ready stalls.
module rv_multicycle_control_fsm #(
  parameter int OPC_WIDTH = 7,
  parameter int STATE_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OPC_WIDTH-1:0] op,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           result_src,
  output logic [2:0]           alu_control,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           imm_src,
  output logic                 reg_write,
  output logic                 illegal,
  output logic [STATE_W-1:0]   state_dbg
);
  typedef enum logic [STATE_W-1:0] {
    FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECR = 6,
    ALUWB = 7, EXECI = 8, JAL = 9, BRANCH = 10, LUI = 11, TRAP = 12
  } state_t;
  localparam logic [OPC_WIDTH-1:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
    OP_R = 7'b0110011, OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BR = 7'b1100011,
    OP_LUI = 7'b0110111;
  state_t state, nxt;
  logic pc_w, mem_w, ir_w, reg_w;
  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub);
    return f3 == 3'b000 ? {2'b00, sub} : f3 == 3'b111 ? 3'b010 : f3 == 3'b110 ? 3'b011 :
           f3 == 3'b100 ? 3'b100 : f3 == 3'b010 ? 3'b101 : 3'b000;
  endfunction
  always_comb begin
    nxt = state;
    case (state)
      FETCH:    nxt = mem_ready ? DECODE : FETCH;
      DECODE:   nxt = (op == OP_LOAD || op == OP_STORE) ? MEMADR : op == OP_R ? EXECR :
                      op == OP_I ? EXECI : op == OP_JAL ? JAL : op == OP_BR ? BRANCH :
                      op == OP_LUI ? LUI : TRAP;
      MEMADR:   nxt = op == OP_STORE ? MEMWRITE : MEMREAD;
      MEMREAD:  nxt = mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: nxt = mem_ready ? FETCH : MEMWRITE;
      EXECR, EXECI, JAL, LUI: nxt = ALUWB;
      MEMWB, ALUWB, BRANCH:   nxt = FETCH;
      TRAP:     nxt = TRAP;
      default:  nxt = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      illegal <= 1'b0;
    end else begin
      state <= nxt;
      illegal <= illegal | (nxt == TRAP);
    end
  end
  always_comb begin
    pc_w = 1'b0;
    mem_w = 1'b0;
    ir_w = 1'b0;
    reg_w = 1'b0;
    adr_src = 1'b0;
    result_src = 2'b00;
    alu_control = 3'b000;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    imm_src = 3'b000;
    case (state)
      FETCH: begin
        alu_src_b = 2'b10;
        result_src = 2'b10;
        ir_w = mem_ready;
        pc_w = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src = 3'b010;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src = op == OP_STORE ? 3'b001 : 3'b000;
      end
      MEMREAD: adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        reg_w = 1'b1;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_w = 1'b1;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_control = alu_dec(funct3, funct7_5);
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_control = alu_dec(funct3, 1'b0);
      end
      ALUWB: reg_w = 1'b1;
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_w = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_control = 3'b001;
        pc_w = funct3 == 3'b000 ? zero : funct3 == 3'b001 ? ~zero : 1'b0;
      end
      LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        imm_src = 3'b100;
      end
      default: ;
    endcase
  end
  // Reset must suppress every strobe in the same cycle, even mid-access.
  assign pc_write = pc_w & ~reset;
  assign mem_write = mem_w & ~reset;
  assign ir_write = ir_w & ~reset;
  assign reg_write = reg_w & ~reset;
  assign state_dbg = state;
endmodule

// File: tb/tb_rv_multicycle_control_fsm.sv
// tb_rv_multicycle_control_fsm: directed checks of the multi-cycle control sequencer.
module tb_rv_multicycle_control_fsm;
  logic clk = 1'b0, reset, funct7_5, zero, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, imm_src;
  logic [3:0] state_dbg;
  int total = 0, bad = 0, irs = 0;

  rv_multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src), .alu_control(alu_control),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src), .reg_write(reg_write),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; op = 7'h00; funct3 = 3'b000; funct7_5 = 1'b0; zero = 1'b0;
    repeat (3) tick();
    chk("rst_state", state_dbg, 0);
    chk("rst_ir", ir_write, 0);
    chk("rst_pc", pc_write, 0);
    chk("rst_mw", mem_write, 0);
    chk("rst_rw", reg_write, 0);
    chk("rst_ill", illegal, 0);
    // R-type sub
    reset = 1'b0; op = 7'b0110011; funct7_5 = 1'b1;
    #1;
    chk("f_ir", ir_write, 1);
    chk("f_pc", pc_write, 1);
    chk("f_bsel", alu_src_b, 2'b10);
    chk("f_res", result_src, 2'b10);
    tick();
    chk("r_dec", state_dbg, 1);
    chk("r_dec_ir", ir_write, 0);
    chk("r_dec_imm", imm_src, 3'b010);
    chk("r_dec_a", alu_src_a, 2'b01);
    tick();
    chk("r_exec", state_dbg, 6);
    chk("r_sub", alu_control, 3'b001);
    chk("r_exec_rw", reg_write, 0);
    chk("r_exec_a", alu_src_a, 2'b10);
    tick();
    chk("r_wb", state_dbg, 7);
    chk("r_wb_rw", reg_write, 1);
    tick();
    chk("r_fetch", state_dbg, 0);
    // I-type with funct3=000 and funct7_5=1 must still add
    op = 7'b0010011; tick(); tick();
    chk("i_exec", state_dbg, 8);
    chk("i_add", alu_control, 3'b000);
    chk("i_bsel", alu_src_b, 2'b01);
    funct3 = 3'b010; #1;
    chk("i_slt", alu_control, 3'b101);
    funct3 = 3'b111; #1;
    chk("i_and", alu_control, 3'b010);
    tick();
    chk("i_wb", state_dbg, 7);
    tick();
    // load with 5 stall cycles in MEMREAD
    op = 7'b0000011; funct3 = 3'b010; tick(); tick();
    chk("ld_adr", state_dbg, 2);
    chk("ld_imm", imm_src, 3'b000);
    mem_ready = 1'b0; tick();
    for (int i = 0; i < 5; i++) begin
      chk("ld_hold", state_dbg, 3);
      chk("ld_asrc", adr_src, 1);
      tick();
    end
    chk("ld_hold_end", state_dbg, 3);
    mem_ready = 1'b1; tick();
    chk("ld_wb", state_dbg, 4);
    chk("ld_res", result_src, 2'b01);
    chk("ld_rw", reg_write, 1);
    tick();
    chk("ld_fetch", state_dbg, 0);
    // store with stalls in FETCH and MEMWRITE
    op = 7'b0100011; mem_ready = 1'b0; irs = 0;
    for (int i = 0; i < 3; i++) begin
      #1 irs += int'(ir_write);
      chk("st_fstall", state_dbg, 0);
      tick();
    end
    mem_ready = 1'b1;
    #1 irs += int'(ir_write);
    tick();
    irs += int'(ir_write);
    chk("st_ir_once", irs, 1);
    tick();
    chk("st_imm", imm_src, 3'b001);
    mem_ready = 1'b0; tick();
    chk("st_mw1", mem_write, 1);
    chk("st_st1", state_dbg, 5);
    tick();
    chk("st_mw2", mem_write, 1);
    mem_ready = 1'b1; #1;
    chk("st_mw3", mem_write, 1);
    chk("st_st3", state_dbg, 5);
    tick();
    chk("st_fetch", state_dbg, 0);
    chk("st_mw_off", mem_write, 0);
    // beq taken, bne not taken (zero=1)
    op = 7'b1100011; funct3 = 3'b000; zero = 1'b1; tick(); tick();
    chk("beq_st", state_dbg, 10);
    chk("beq_pc", pc_write, 1);
    chk("beq_sub", alu_control, 3'b001);
    tick();
    chk("beq_fetch", state_dbg, 0);
    funct3 = 3'b001; tick(); tick();
    chk("bne_pc", pc_write, 0);
    zero = 1'b0; #1;
    chk("bne_pc_nz", pc_write, 1);
    funct3 = 3'b100; #1;
    chk("bx_pc", pc_write, 0);
    tick();
    chk("bne_fetch", state_dbg, 0);
    // jal and lui
    op = 7'b1101111; tick(); tick();
    chk("jal_st", state_dbg, 9);
    chk("jal_pc", pc_write, 1);
    tick();
    chk("jal_wb", state_dbg, 7);
    tick();
    op = 7'b0110111; tick(); tick();
    chk("lui_st", state_dbg, 11);
    chk("lui_imm", imm_src, 3'b100);
    chk("lui_a", alu_src_a, 2'b11);
    tick(); tick();
    // reset during MEMWRITE suppresses the strobe
    op = 7'b0100011; mem_ready = 1'b1; tick(); tick();
    mem_ready = 1'b0; tick();
    chk("mr_st", state_dbg, 5);
    reset = 1'b1; #1;
    chk("mr_mw", mem_write, 0);
    tick();
    chk("mr_fetch", state_dbg, 0);
    reset = 1'b0; mem_ready = 1'b1;
    // illegal opcode traps
    op = 7'b1111111; tick(); tick();
    chk("trap_st", state_dbg, 12);
    chk("trap_ill", illegal, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("trap_hold", {state_dbg, illegal, pc_write, ir_write, mem_write, reg_write}, {4'd12, 5'b10000});
    end
    reset = 1'b1; tick();
    reset = 1'b0; #1;
    chk("trap_clr", illegal, 0);
    chk("trap_fetch", state_dbg, 0);
    chk("trap_ir", ir_write, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
